// File: rtl/gat_pkg.sv
// Shared types for the GAT BRAM port bridge.
// Load channel states and sticky error bit positions.
package gat_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        DONE
    } load_state_e;

    typedef enum logic [1:0] {
        ERR_ALIGN,
        ERR_RANGE,
        ERR_LOCK,
        ERR_OVF
    } err_bit_e;

    localparam int ERR_W = 4;

endpackage

// File: rtl/gat_bram_load_chan.sv
// One load channel: write checks, word counter, done FSM
// and the registered internal BRAM write port.
module gat_bram_load_chan
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH = 32,
    parameter int DATA_W    = 20,
    parameter int DEPTH     = 13264,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TOP_WIDTH-1:0] din,
    input  logic                 ena,
    input  logic                 wea,
    input  logic [ADDR_W+1:0]    addra,
    input  logic [ADDR_W:0]      cfg_len,
    input  logic                 load_clr,
    input  logic                 core_busy,
    output logic [DATA_W-1:0]    m_din,
    output logic                 m_ena,
    output logic                 m_wea,
    output logic [ADDR_W-1:0]    m_addra,
    output logic                 load_done,
    output logic [ERR_W-1:0]     err
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    load_state_e       state;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [ADDR_W-1:0] waddr;
    logic              wr;
    logic              full;
    logic              din_unused;

    assign wr         = ena & wea;
    assign waddr      = addra[ADDR_W+1:2];
    assign cnt_nxt    = cnt + 1'b1;
    // A zero length disables the channel: it behaves as already loaded.
    assign full       = (cfg_len == '0) | (state == DONE);
    assign load_done  = full;
    assign m_ena      = m_wea;
    assign din_unused = ^din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            err     <= '0;
            m_wea   <= 1'b0;
            m_din   <= '0;
            m_addra <= '0;
        end else begin
            m_wea <= 1'b0;
            if (load_clr) begin
                state <= IDLE;
                cnt   <= '0;
                err   <= '0;
            end else if (wr) begin
                if (addra[1:0] != 2'b00) begin
                    err[ERR_ALIGN] <= 1'b1;
                end else if ({1'b0, waddr} >= LIMIT) begin
                    err[ERR_RANGE] <= 1'b1;
                end else if (core_busy) begin
                    err[ERR_LOCK] <= 1'b1;
                end else if (full) begin
                    err[ERR_OVF] <= 1'b1;
                end else begin
                    m_wea   <= 1'b1;
                    m_din   <= din[DATA_W-1:0];
                    m_addra <= waddr;
                    cnt     <= cnt_nxt;
                    state   <= (cnt_nxt == cfg_len) ? DONE : LOADING;
                end
            end
        end
    end

endmodule

// File: rtl/gat_bram_port_bridge.sv
// PS-side BRAM ports to GAT core BRAMs: NUM_CH load
// channels with done tracking plus one readback port.
module gat_bram_port_bridge
    import gat_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TOP_WIDTH   = 32,
    parameter int DATA_W      = 20,
    parameter int DEPTH       = 13264,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int RD_DATA_W   = 32,
    parameter int RD_DEPTH    = 43328,
    parameter int RD_ADDR_W   = $clog2(RD_DEPTH),
    parameter int RD_LATENCY  = 1,
    parameter bit RD_SIGN_EXT = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*TOP_WIDTH-1:0] s_din,
    input  logic [NUM_CH-1:0]           s_ena,
    input  logic [NUM_CH-1:0]           s_wea,
    input  logic [NUM_CH*(ADDR_W+2)-1:0] s_addra,
    input  logic [NUM_CH*(ADDR_W+1)-1:0] cfg_len,
    input  logic                        load_clr,
    input  logic                        core_busy,
    output logic [NUM_CH*DATA_W-1:0]    m_din,
    output logic [NUM_CH-1:0]           m_ena,
    output logic [NUM_CH-1:0]           m_wea,
    output logic [NUM_CH*ADDR_W-1:0]    m_addra,
    output logic [NUM_CH-1:0]           load_done,
    output logic                        all_loaded,
    output logic [NUM_CH-1:0]           err_align,
    output logic [NUM_CH-1:0]           err_range,
    output logic [NUM_CH-1:0]           err_ovf,
    output logic [NUM_CH-1:0]           err_lock,
    input  logic                        rd_ena,
    input  logic [RD_ADDR_W+1:0]        rd_addrb,
    output logic                        m_rd_en,
    output logic [RD_ADDR_W-1:0]        m_rd_addrb,
    input  logic [RD_DATA_W-1:0]        m_rd_dout,
    output logic [TOP_WIDTH-1:0]        rd_dout,
    output logic                        rd_valid
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ERR_W-1:0] err;

        gat_bram_load_chan #(
            .TOP_WIDTH (TOP_WIDTH),
            .DATA_W    (DATA_W),
            .DEPTH     (DEPTH),
            .ADDR_W    (ADDR_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .din       (s_din[c*TOP_WIDTH +: TOP_WIDTH]),
            .ena       (s_ena[c]),
            .wea       (s_wea[c]),
            .addra     (s_addra[c*(ADDR_W+2) +: ADDR_W+2]),
            .cfg_len   (cfg_len[c*(ADDR_W+1) +: ADDR_W+1]),
            .load_clr  (load_clr),
            .core_busy (core_busy),
            .m_din     (m_din[c*DATA_W +: DATA_W]),
            .m_ena     (m_ena[c]),
            .m_wea     (m_wea[c]),
            .m_addra   (m_addra[c*ADDR_W +: ADDR_W]),
            .load_done (load_done[c]),
            .err       (err)
        );

        assign err_align[c] = err[ERR_ALIGN];
        assign err_range[c] = err[ERR_RANGE];
        assign err_lock[c]  = err[ERR_LOCK];
        assign err_ovf[c]   = err[ERR_OVF];
    end

    assign all_loaded = &load_done;

    logic [RD_LATENCY-1:0] vld;
    logic [TOP_WIDTH-1:0]  rd_ext;
    logic [TOP_WIDTH-1:0]  rd_hold;
    logic                  rd_unused;

    assign rd_unused = ^rd_addrb[1:0];
    assign rd_ext    = RD_SIGN_EXT ? TOP_WIDTH'($signed(m_rd_dout))
                                   : TOP_WIDTH'(m_rd_dout);
    assign rd_valid  = vld[RD_LATENCY-1];
    // Data is passed through on its valid cycle and held afterwards.
    assign rd_dout   = rd_valid ? rd_ext : rd_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd_en    <= 1'b0;
            m_rd_addrb <= '0;
            vld        <= '0;
            rd_hold    <= '0;
        end else begin
            m_rd_en <= rd_ena;
            if (rd_ena) begin
                m_rd_addrb <= rd_addrb[RD_ADDR_W+1:2];
            end
            vld[0] <= m_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
            if (rd_valid) begin
                rd_hold <= rd_ext;
            end
        end
    end

endmodule

// File: tb/tb_gat_bram_port_bridge.sv
// Scoreboard bench for gat_bram_port_bridge: directed writes
// and reads queue expectations, a monitor checks outputs.
module tb_gat_bram_port_bridge;

    localparam int NC  = 4;
    localparam int AW  = 5;
    localparam int DW  = 20;
    localparam int RAW = 16;

    typedef struct {
        int             ch;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
    } wexp_t;

    typedef struct {
        logic [31:0] d;
        int          cyc;
    } rexp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NC*32-1:0]     s_din;
    logic [NC-1:0]        s_ena;
    logic [NC-1:0]        s_wea;
    logic [NC*(AW+2)-1:0] s_addra;
    logic [NC*(AW+1)-1:0] cfg_len;
    logic                 load_clr;
    logic                 core_busy;
    logic [NC*DW-1:0]     m_din;
    logic [NC-1:0]        m_ena;
    logic [NC-1:0]        m_wea;
    logic [NC*AW-1:0]     m_addra;
    logic [NC-1:0]        load_done;
    logic                 all_loaded;
    logic [NC-1:0]        err_align;
    logic [NC-1:0]        err_range;
    logic [NC-1:0]        err_ovf;
    logic [NC-1:0]        err_lock;
    logic                 rd_ena;
    logic [RAW+1:0]       rd_addrb;
    logic                 m_rd_en;
    logic [RAW-1:0]       m_rd_addrb;
    logic [31:0]          m_rd_dout = '0;
    logic [31:0]          p1 = '0;
    logic [31:0]          rd_dout;
    logic                 rd_valid;

    int    nvec = 0;
    int    nerr = 0;
    int    cyc  = 0;
    wexp_t wq[$];
    rexp_t rq[$];

    gat_bram_port_bridge #(
        .NUM_CH      (NC),
        .TOP_WIDTH   (32),
        .DATA_W      (DW),
        .DEPTH       (16),
        .ADDR_W      (AW),
        .RD_DATA_W   (32),
        .RD_DEPTH    (43328),
        .RD_ADDR_W   (RAW),
        .RD_LATENCY  (2),
        .RD_SIGN_EXT (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_din      (s_din),
        .s_ena      (s_ena),
        .s_wea      (s_wea),
        .s_addra    (s_addra),
        .cfg_len    (cfg_len),
        .load_clr   (load_clr),
        .core_busy  (core_busy),
        .m_din      (m_din),
        .m_ena      (m_ena),
        .m_wea      (m_wea),
        .m_addra    (m_addra),
        .load_done  (load_done),
        .all_loaded (all_loaded),
        .err_align  (err_align),
        .err_range  (err_range),
        .err_ovf    (err_ovf),
        .err_lock   (err_lock),
        .rd_ena     (rd_ena),
        .rd_addrb   (rd_addrb),
        .m_rd_en    (m_rd_en),
        .m_rd_addrb (m_rd_addrb),
        .m_rd_dout  (m_rd_dout),
        .rd_dout    (rd_dout),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [RAW-1:0] a);
        case (a)
            16'd0:   return 32'h8000_0000;
            16'd1:   return 32'h0000_0001;
            default: return {16'h0, a} * 3;
        endcase
    endfunction

    // Two-cycle BRAM read model.
    always @(posedge clk) begin
        p1        <= memf(m_rd_addrb);
        m_rd_dout <= p1;
    end

    task automatic chk(input string nm,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wexp_t we;
        rexp_t re;
        if (rst_n) begin
            if (|(m_wea | m_ena)) chk("m_ena_eq_wea", m_ena, m_wea);
            for (int c = 0; c < NC; c++) begin
                if (m_wea[c]) begin
                    if (wq.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_wr ch%0d: got m_wea=1 expected none", c);
                    end else begin
                        we = wq.pop_front();
                        chk("wr_ch", c, we.ch);
                        chk("wr_addr", m_addra[c*AW +: AW], we.a);
                        chk("wr_din", m_din[c*DW +: DW], we.d);
                    end
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_rd: got rd_valid=1 expected none");
                end else begin
                    re = rq.pop_front();
                    chk("rd_dout", rd_dout, re.d);
                    chk("rd_cycle", cyc, re.cyc);
                end
            end
        end
    end

    task automatic wr(input int c, input logic [6:0] a, input logic [31:0] d,
                      input bit acc, input logic [AW-1:0] ea,
                      input logic [DW-1:0] ed);
        @(negedge clk);
        s_ena[c] = 1'b1;
        s_wea[c] = 1'b1;
        s_addra[c*(AW+2) +: AW+2] = a;
        s_din[c*32 +: 32] = d;
        if (acc) wq.push_back('{c, ea, ed});
        @(negedge clk);
        s_ena[c] = 1'b0;
        s_wea[c] = 1'b0;
    endtask

    task automatic rd(input logic [RAW+1:0] a, input logic [31:0] ed);
        @(negedge clk);
        rd_ena   = 1'b1;
        rd_addrb = a;
        rq.push_back('{ed, cyc + 3});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        s_din     = '0;
        s_ena     = '0;
        s_wea     = '0;
        s_addra   = '0;
        load_clr  = 1'b0;
        core_busy = 1'b0;
        rd_ena    = 1'b0;
        rd_addrb  = '0;
        cfg_len   = {6'd0, 6'd4, 6'd2, 6'd3};
        repeat (2) @(negedge clk);
        chk("rst_m_wea", m_wea, 0);
        chk("rst_m_addra", m_addra, 0);
        chk("rst_m_din", m_din, 0);
        chk("rst_done", load_done, 4'b1000);
        chk("rst_all", all_loaded, 0);
        chk("rst_err", {err_align, err_range, err_lock, err_ovf}, 0);
        chk("rst_rd", {m_rd_en, rd_valid, rd_dout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        wr(0, 7'h00, 32'hFFFF_F123, 1, 5'd0, 20'hFF123);
        wr(0, 7'h04, 32'hFFFF_F123, 1, 5'd1, 20'hFF123);
        chk("ld0_mid", load_done[0], 0);
        wr(0, 7'h06, 32'h0000_0055, 0, 5'd0, 20'h0);
        chk("align0", err_align, 4'b0001);
        wr(0, 7'h08, 32'hFFFF_F123, 1, 5'd2, 20'hFF123);
        chk("ld0_final", load_done[0], 1);

        wr(2, 7'h3C, 32'h1234_5678, 1, 5'd15, 20'h45678);
        wr(2, 7'h40, 32'h0000_0001, 0, 5'd0, 20'h0);
        chk("range2", err_range, 4'b0100);
        chk("ld2_open", load_done[2], 0);

        wr(1, 7'h00, 32'h000A_BCDE, 1, 5'd0, 20'hABCDE);
        wr(1, 7'h04, 32'h0000_0001, 1, 5'd1, 20'h00001);
        chk("ld1", load_done[1], 1);
        chk("all_mid", all_loaded, 0);
        wr(1, 7'h08, 32'h0000_0007, 0, 5'd0, 20'h0);
        chk("ovf1", err_ovf, 4'b0010);

        @(negedge clk);
        load_clr = 1'b1;
        s_ena[1] = 1'b1;
        s_wea[1] = 1'b1;
        s_addra[(AW+2) +: AW+2] = 7'h08;
        @(negedge clk);
        load_clr = 1'b0;
        s_ena[1] = 1'b0;
        s_wea[1] = 1'b0;
        chk("clr_err", {err_align, err_range, err_lock, err_ovf}, 0);
        chk("clr_done", load_done, 4'b1000);
        wr(1, 7'h00, 32'h0000_0011, 1, 5'd0, 20'h00011);
        chk("clr_cnt", load_done[1], 0);
        wr(1, 7'h04, 32'h0000_0022, 1, 5'd1, 20'h00022);
        chk("reload1", load_done[1], 1);

        core_busy = 1'b1;
        wr(2, 7'h00, 32'h0000_0003, 0, 5'd0, 20'h0);
        chk("lock2", err_lock, 4'b0100);
        wr(0, 7'h06, 32'h0000_0003, 0, 5'd0, 20'h0);
        wr(2, 7'h42, 32'h0000_0003, 0, 5'd0, 20'h0);
        chk("prio", {err_align, err_range, err_lock}, {4'b0101, 4'b0000, 4'b0100});
        core_busy = 1'b0;
        wr(3, 7'h00, 32'h0000_0009, 0, 5'd0, 20'h0);
        chk("ovf3", err_ovf, 4'b1000);

        wr(0, 7'h00, 32'h0000_0001, 1, 5'd0, 20'h00001);
        wr(0, 7'h04, 32'h0010_0002, 1, 5'd1, 20'h00002);
        wr(0, 7'h08, 32'h000F_FFFF, 1, 5'd2, 20'hFFFFF);
        chk("ld0_again", load_done[0], 1);
        wr(2, 7'h10, 32'h0000_0010, 1, 5'd4, 20'h00010);
        wr(2, 7'h14, 32'h0000_0020, 1, 5'd5, 20'h00020);
        wr(2, 7'h18, 32'h0000_0030, 1, 5'd6, 20'h00030);
        chk("all_pre", all_loaded, 0);
        wr(2, 7'h3C, 32'hFFF0_0040, 1, 5'd15, 20'h00040);
        chk("all_done", all_loaded, 1);

        rd(18'h0, 32'h8000_0000);
        rd(18'h4, 32'h0000_0001);
        rd(18'h9, 32'h0000_0006);
        @(negedge clk);
        rd_ena = 1'b0;
        repeat (5) @(negedge clk);
        chk("rd_hold", {rd_valid, rd_dout}, {1'b0, 32'h0000_0006});
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
